// File: rtl/oh_fork4_if.sv
// Handshake bundle for the 4-way fork: one producer stream in, four consumer branches out.
// valid/ready rule for every channel: a word moves on a rising edge where valid and ready are both high;
// a sender holds valid and data steady until that edge, and ready never waits on valid.
interface oh_fork4_if #(
  parameter int DW = 1
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [3:0]    in_mask;
  logic          in_ready;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    out_ready;

  // master: the surrounding fabric (producer plus the four consumers)
  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data
  );

  // slave: the fork itself
  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/oh_fork4.sv
// Registered 4-way ready/valid fork: holds one word and broadcasts it until every
// selected branch has taken it. Each branch retires independently.
module oh_fork4 #(
  parameter int DW = 1
) (
  input  logic       clk,
  input  logic       reset,
  oh_fork4_if.slave  io
);
  logic [3:0]    pending;
  logic [3:0]    done_next;
  logic [DW-1:0] data_q;
  logic          accept;

  // Ready as soon as nothing will still be owed after this edge, which lets a new word
  // load on the same edge the last branch completes.
  assign io.in_ready  = ~reset & (done_next == 4'b0000);
  assign accept       = io.in_valid & io.in_ready;
  assign io.out_valid = pending;
  assign io.out_data  = data_q;

  for (genvar i = 0; i < 4; i++) begin : g_branch
    assign done_next[i] = pending[i] & ~io.out_ready[i];

    always_ff @(posedge clk) begin
      if (reset)       pending[i] <= 1'b0;
      else if (accept) pending[i] <= io.in_mask[i];
      else             pending[i] <= done_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       data_q <= '0;
    else if (accept) data_q <= io.in_data;
  end
endmodule
